iter_controller: RTL and testbench
==================================

Name: iter_controller

Overview:
- Parametrised successor to the single-channel iterative compute controller (init / multiply / add / write-back / check loop).
- Sequences N_CH datapath channels per iteration through MULT, ADD and WB phases, with a configurable multiply latency.
- Counts iterations internally and stops on either the datapath's isfinished flag or an iteration limit.
- Sits between the top-level start/done interface and the weight, input and accumulator registers of the datapath.

Parameters:
- N_CH, 4, number of channels processed sequentially per iteration (>=1)
- MULT_LAT, 1, cycles spent in MULT per channel (>=1)
- MAX_ITER, 16, iteration limit before forced termination (>=1)
- CH_W, $clog2(N_CH) (min 1), width of ch_idx
- IT_W, $clog2(MAX_ITER+1), width of iter_cnt

Ports:
- clk, input, 1, clock, rising edge
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, level request; run begins on its release
- abort, input, 1, synchronous cancel of a run in progress
- isfinished, input, 1, datapath convergence flag, sampled only in CHECK
- init_w, output, 1, load initial weights
- init_x, output, 1, load initial inputs
- load_sel, output, 1, accumulator mux selects the init source
- load_a, output, 1, accumulator register load enable
- mult_en, output, 1, multiplier enable
- add_en, output, 1, adder enable
- ch_idx, output, CH_W, channel currently addressed
- iter_cnt, output, IT_W, completed iterations in this run
- busy, output, 1, high in every state except IDLE
- done, output, 1, one-cycle completion pulse
- timeout, output, 1, sticky flag: last run hit MAX_ITER without isfinished

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, ch_idx=0, iter_cnt=0, mult counter=0, timeout=0. All outputs low except ch_idx and iter_cnt, which read 0.
- States: IDLE, INIT, MULT, ADD, WB, CHECK, DONE. Registered state; outputs are decoded from state (Moore). The next-state logic is fully combinational and sensitive to all inputs and state.
- IDLE:
  - start=1 -> INIT; stay otherwise.
  - On leaving IDLE: iter_cnt<=0, ch_idx<=0, timeout<=0.
- INIT:
  - Outputs init_w=init_x=load_a=load_sel=1.
  - Stay while start=1; start=0 -> MULT.
- MULT:
  - mult_en=1. The internal counter counts 0..MULT_LAT-1.
  - Exit to ADD in the cycle the counter reads MULT_LAT-1; the counter clears on exit.
  - With MULT_LAT=1, MULT lasts exactly one cycle.
- ADD: add_en=1; one cycle -> WB.
- WB:
  - load_a=1; one cycle.
  - If ch_idx<N_CH-1: ch_idx++ and go to MULT.
  - Otherwise ch_idx<=0 and go to CHECK.
- CHECK:
  - iter_cnt increments on entry, so it reads k+1 after the k-th iteration.
  - isfinished=1 -> DONE.
  - Else iter_cnt==MAX_ITER -> DONE with timeout<=1.
  - Else -> MULT.
  - isfinished takes priority when both conditions hold in the same cycle; timeout stays 0.
- DONE: done=1 for exactly one cycle -> IDLE. iter_cnt and timeout hold until the next run starts.
- Latency per iteration: N_CH*(MULT_LAT+2)+1 cycles.
- abort=1 in any state other than IDLE or DONE -> DONE on the next edge. timeout is not set; iter_cnt keeps its current value.
- abort in IDLE is ignored. If abort=1 and start=1 together in IDLE, the controller enters INIT.
- rst_n asserted mid-run returns to IDLE immediately, with no done pulse.
- Unreachable state encodings -> IDLE.

Decomposition:
- Shared package iter_ctrl_pkg holds:
  - state encoding constants (3-bit): IDLE=0, INIT=1, MULT=2, ADD=3, WB=4, CHECK=5, DONE=6
  - an enum/typedef for the state type
- Sub-module mod_counter (parametrised width, terminal value, enable, clear, terminal-count output). Instantiated three times: for the MULT latency, ch_idx and iter_cnt.

Test Plan:
- N_CH=1, MULT_LAT=1: start pulse of 3 cycles then 0, isfinished=1 at the first CHECK -> INIT outputs high for 3 cycles; MULT, ADD, WB, CHECK, DONE follow; done high for exactly 1 cycle; iter_cnt=1; timeout=0.
- N_CH=4, MULT_LAT=3, isfinished=1 at the 2nd CHECK -> ch_idx steps 0,1,2,3 in each iteration; 21 cycles between CHECKs; iter_cnt=2 at done; load_a pulses 8 times after INIT.
- MAX_ITER=5, isfinished held at 0 -> DONE after the 5th CHECK; timeout=1; iter_cnt=5. The next start clears timeout to 0.
- isfinished=1 in the same CHECK where iter_cnt reaches MAX_ITER -> done pulses; timeout=0.
- abort=1 in MULT during iteration 2 -> done pulses on the next cycle; iter_cnt=1; busy=0 afterwards.
- rst_n driven low asynchronously mid-ADD, between clock edges -> all outputs drop to 0 immediately; state is IDLE after release; no done pulse.

Source files
------------

// File: rtl/iter_ctrl_pkg.sv
// Shared types for the iterative compute controller: state encoding and
// the Moore output decode used to build the registered control outputs.
package iter_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_MULT  = 3'd2,
    S_ADD   = 3'd3,
    S_WB    = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  typedef struct packed {
    logic init_w;
    logic init_x;
    logic load_sel;
    logic load_a;
    logic mult_en;
    logic add_en;
    logic busy;
    logic done;
  } ctrl_t;

  // Datapath strobes implied by a given state.
  function automatic ctrl_t decode_ctrl(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_INIT: begin
        c.init_w   = 1'b1;
        c.init_x   = 1'b1;
        c.load_sel = 1'b1;
        c.load_a   = 1'b1;
      end
      S_MULT:  c.mult_en = 1'b1;
      S_ADD:   c.add_en  = 1'b1;
      S_WB:    c.load_a  = 1'b1;
      S_DONE:  c.done    = 1'b1;
      default: ;
    endcase
    c.busy = (s != S_IDLE);
    return c;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Wrapping up-counter: counts 0..TERM under enable, clear has priority,
// tc flags the terminal value.
module mod_counter #(
  parameter int W    = 4,
  parameter int TERM = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] TERM_V = W'(TERM);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise step and wrap at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERM_V) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == TERM_V);

endmodule

// File: rtl/iter_controller.sv
// Iterative compute controller: walks N_CH channels per iteration through
// MULT/ADD/WB, then CHECK decides between another iteration and DONE.
//
//   state | meaning
//   IDLE  | waiting for start
//   INIT  | loading initial weights/inputs while start is held
//   MULT  | multiplier running for MULT_LAT cycles on channel ch_idx
//   ADD   | adder strobe for channel ch_idx
//   WB    | accumulator write-back, advance channel
//   CHECK | iteration complete: converged, limit reached, or loop
//   DONE  | one-cycle completion pulse
module iter_controller #(
  parameter int N_CH     = 4,
  parameter int MULT_LAT = 1,
  parameter int MAX_ITER = 16,
  parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  parameter int IT_W     = $clog2(MAX_ITER + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            isfinished,
  output logic            init_w,
  output logic            init_x,
  output logic            load_sel,
  output logic            load_a,
  output logic            mult_en,
  output logic            add_en,
  output logic [CH_W-1:0] ch_idx,
  output logic [IT_W-1:0] iter_cnt,
  output logic            busy,
  output logic            done,
  output logic            timeout
);

  import iter_ctrl_pkg::*;

  localparam int ML_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  state_e          state_q;
  state_e          state_d;
  ctrl_t           ctrl_q;
  ctrl_t           ctrl_d;
  logic            timeout_q;
  logic            timeout_d;

  logic [ML_W-1:0] mult_cnt;
  logic            mult_tc;
  logic            ch_tc;
  logic            iter_tc;

  logic            abort_run;
  logic            run_clr;
  logic            mult_cnt_en;
  logic            mult_cnt_clr;
  logic            ch_cnt_en;
  logic            iter_cnt_en;

  // Counter control: an abort freezes every counter so iter_cnt keeps its value.
  always_comb begin
    abort_run    = abort && (state_q != S_IDLE) && (state_q != S_DONE);
    run_clr      = (state_q == S_IDLE) && start;
    mult_cnt_en  = (state_q == S_MULT) && !abort_run;
    // Only an abort can leave the latency counter mid-count outside MULT.
    mult_cnt_clr = (state_q != S_MULT) && (mult_cnt != '0);
    ch_cnt_en    = (state_q == S_WB) && !abort_run;
    iter_cnt_en  = ch_cnt_en && ch_tc;
  end

  mod_counter #(.W(ML_W), .TERM(MULT_LAT - 1)) u_mult_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (mult_cnt_en),
    .clr  (mult_cnt_clr),
    .cnt  (mult_cnt),
    .tc   (mult_tc)
  );

  mod_counter #(.W(CH_W), .TERM(N_CH - 1)) u_ch_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ch_cnt_en),
    .clr  (run_clr),
    .cnt  (ch_idx),
    .tc   (ch_tc)
  );

  mod_counter #(.W(IT_W), .TERM(MAX_ITER)) u_iter_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (iter_cnt_en),
    .clr  (run_clr),
    .cnt  (iter_cnt),
    .tc   (iter_tc)
  );

  // Next state, next outputs and the sticky timeout flag.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  if (!start) state_d = S_MULT;
      S_MULT:  if (mult_tc) state_d = S_ADD;
      S_ADD:   state_d = S_WB;
      S_WB:    state_d = ch_tc ? S_CHECK : S_MULT;
      S_CHECK: state_d = (isfinished || iter_tc) ? S_DONE : S_MULT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_run) begin
      state_d = S_DONE;
    end

    ctrl_d = decode_ctrl(state_d);

    timeout_d = timeout_q;
    if (run_clr) begin
      timeout_d = 1'b0;
    end else if ((state_q == S_CHECK) && !abort_run && !isfinished && iter_tc) begin
      timeout_d = 1'b1;
    end
  end

  // State and registered Moore outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      timeout_q <= timeout_d;
    end
  end

  assign init_w   = ctrl_q.init_w;
  assign init_x   = ctrl_q.init_x;
  assign load_sel = ctrl_q.load_sel;
  assign load_a   = ctrl_q.load_a;
  assign mult_en  = ctrl_q.mult_en;
  assign add_en   = ctrl_q.add_en;
  assign busy     = ctrl_q.busy;
  assign done     = ctrl_q.done;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_iter_controller.sv
// Bench for iter_controller: two configurations checked every cycle against
// a schedule-based model, plus directed scenarios with literal expectations.
module tb_iter_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] st;
  logic [1:0] ab;
  logic [1:0] fi;

  logic       iw0, ix0, ls0, la0, me0, ae0, b0, d0, to0;
  logic [1:0] ch0;
  logic [2:0] it0;
  logic       iw1, ix1, ls1, la1, me1, ae1, b1, d1, to1;
  logic       ch1;
  logic [1:0] it1;

  always #5 clk = ~clk;

  iter_controller #(.N_CH(4), .MULT_LAT(3), .MAX_ITER(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .abort(ab[0]), .isfinished(fi[0]),
    .init_w(iw0), .init_x(ix0), .load_sel(ls0), .load_a(la0), .mult_en(me0),
    .add_en(ae0), .ch_idx(ch0), .iter_cnt(it0), .busy(b0), .done(d0), .timeout(to0)
  );

  iter_controller #(.N_CH(1), .MULT_LAT(1), .MAX_ITER(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .abort(ab[1]), .isfinished(fi[1]),
    .init_w(iw1), .init_x(ix1), .load_sel(ls1), .load_a(la1), .mult_en(me1),
    .add_en(ae1), .ch_idx(ch1), .iter_cnt(it1), .busy(b1), .done(d1), .timeout(to1)
  );

  // {init_w, init_x, load_sel, load_a, mult_en, add_en, busy, done, timeout}
  logic [8:0] act_ctrl [2];
  logic [7:0] act_ch   [2];
  logic [7:0] act_it   [2];

  always_comb begin
    act_ctrl[0] = {iw0, ix0, ls0, la0, me0, ae0, b0, d0, to0};
    act_ctrl[1] = {iw1, ix1, ls1, la1, me1, ae1, b1, d1, to1};
    act_ch[0]   = {6'd0, ch0};
    act_ch[1]   = {7'd0, ch1};
    act_it[0]   = {5'd0, it0};
    act_it[1]   = {6'd0, it1};
  end

  int NCH  [2] = '{4, 1};
  int LAT  [2] = '{3, 1};
  int MAXI [2] = '{5, 3};

  int n_assert = 0;
  int n_fail   = 0;
  int cyc_n    = 0;

  task automatic chk(input string nm, input int d, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Model: run position t counts cycles since the first MULT of the run.
  // One iteration is P = N*(L+2)+1 cycles: per channel L MULT, ADD, WB, then CHECK.
  int m_mode [2];   // 0 idle, 1 init, 2 running, 3 done
  int m_t    [2];
  int m_iter [2];
  int m_ch   [2];
  bit m_to   [2];

  function automatic int period(input int d);
    return NCH[d] * (LAT[d] + 2) + 1;
  endfunction

  function automatic int ch_at(input int d, input int t);
    int o;
    o = t % period(d);
    return (o == period(d) - 1) ? 0 : o / (LAT[d] + 2);
  endfunction

  task automatic model_step(input int d);
    int o;
    case (m_mode[d])
      0: if (st[d]) begin
        m_mode[d] = 1; m_iter[d] = 0; m_ch[d] = 0; m_to[d] = 1'b0;
      end
      1: if (ab[d]) m_mode[d] = 3;
         else if (!st[d]) begin m_mode[d] = 2; m_t[d] = 0; m_ch[d] = 0; end
      2: if (ab[d]) m_mode[d] = 3;
         else begin
           o = m_t[d] % period(d);
           if (o == period(d) - 1) begin
             if (fi[d]) m_mode[d] = 3;
             else if (m_iter[d] == MAXI[d]) begin m_mode[d] = 3; m_to[d] = 1'b1; end
             else m_t[d]++;
           end else begin
             if ((o % (LAT[d] + 2) == LAT[d] + 1) && (o / (LAT[d] + 2) == NCH[d] - 1))
               m_iter[d]++;
             m_t[d]++;
           end
           if (m_mode[d] == 2) m_ch[d] = ch_at(d, m_t[d]);
         end
      default: m_mode[d] = 0;
    endcase
  endtask

  function automatic int exp_ctrl(input int d);
    logic [8:0] e;
    int o, sub;
    e    = '0;
    e[0] = m_to[d];
    case (m_mode[d])
      1: begin e[8:5] = 4'b1111; e[2] = 1'b1; end
      2: begin
        e[2] = 1'b1;
        o = m_t[d] % period(d);
        if (o != period(d) - 1) begin
          sub = o % (LAT[d] + 2);
          if (sub < LAT[d]) e[4] = 1'b1;
          else if (sub == LAT[d]) e[3] = 1'b1;
          else e[5] = 1'b1;
        end
      end
      3: begin e[2] = 1'b1; e[1] = 1'b1; end
      default: ;
    endcase
    return int'(e);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_mode[d] = 0; m_t[d] = 0; m_iter[d] = 0; m_ch[d] = 0; m_to[d] = 1'b0;
      end else begin
        model_step(d);
      end
    end
  end

  // Per-run observations used by the directed scenarios.
  int done_cnt [2];
  int iter_at_done [2];
  int to_at_done [2];
  int init_cyc [2];
  int loada_cnt [2];
  int chk_cnt [2];
  int last_chk [2];
  int chk_gap [2];

  initial forever begin
    @(negedge clk);
    cyc_n++;
    for (int d = 0; d < 2; d++) begin
      chk("ctrl", d, int'(act_ctrl[d]), exp_ctrl(d));
      chk("ch_idx", d, int'(act_ch[d]), m_ch[d]);
      chk("iter_cnt", d, int'(act_it[d]), m_iter[d]);
      if (act_ctrl[d][1]) begin
        done_cnt[d]++;
        iter_at_done[d] = int'(act_it[d]);
        to_at_done[d]   = int'(act_ctrl[d][0]);
      end
      if (act_ctrl[d][8]) init_cyc[d]++;
      if (act_ctrl[d][5] && !act_ctrl[d][8]) loada_cnt[d]++;
      if (act_ctrl[d][8:1] == 8'b0000_0010) begin
        chk_cnt[d]++;
        if (last_chk[d] >= 0) chk_gap[d] = cyc_n - last_chk[d];
        last_chk[d] = cyc_n;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic reset_mon(input int d);
    done_cnt[d] = 0; iter_at_done[d] = -1; to_at_done[d] = -1; init_cyc[d] = 0;
    loada_cnt[d] = 0; chk_cnt[d] = 0; last_chk[d] = -1; chk_gap[d] = -1;
  endtask

  task automatic pulse_start(input int d, input int n);
    st[d] = 1'b1;
    cyc(n);
    st[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    int base;
    bit seen;
    base = done_cnt[d];
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc(1);
      if (done_cnt[d] > base) seen = 1'b1;
    end
    chk("done_seen", d, int'(seen), 1);
  endtask

  task automatic wait_chk(input int d, input int n, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc(1);
      if (chk_cnt[d] >= n) seen = 1'b1;
    end
    chk("check_seen", d, int'(seen), 1);
  endtask

  initial begin
    rst_n = 1'b0; st = '0; ab = '0; fi = '0;
    reset_mon(0); reset_mon(1);
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ctrl", d, int'(act_ctrl[d]), 0);
      chk("rst_ch", d, int'(act_ch[d]), 0);
      chk("rst_iter", d, int'(act_it[d]), 0);
    end
    rst_n = 1'b1;
    cyc(2);

    // Single channel, latency 1, converges at the first CHECK.
    reset_mon(1);
    fi[1] = 1'b1;
    pulse_start(1, 3);
    wait_done(1, 40);
    cyc(3);
    fi[1] = 1'b0;
    chk("s1_init_cycles", 1, init_cyc[1], 3);
    chk("s1_done_cycles", 1, done_cnt[1], 1);
    chk("s1_iter", 1, iter_at_done[1], 1);
    chk("s1_timeout", 1, to_at_done[1], 0);
    chk("s1_checks", 1, chk_cnt[1], 1);

    // Four channels, latency 3, converges at the second CHECK.
    reset_mon(0);
    pulse_start(0, 1);
    wait_chk(0, 1, 60);
    fi[0] = 1'b1;
    wait_done(0, 60);
    fi[0] = 1'b0;
    cyc(2);
    chk("s2_checks", 0, chk_cnt[0], 2);
    chk("s2_check_gap", 0, chk_gap[0], 21);
    chk("s2_iter", 0, iter_at_done[0], 2);
    chk("s2_timeout", 0, to_at_done[0], 0);
    chk("s2_load_a", 0, loada_cnt[0], 8);
    chk("s2_done_cycles", 0, done_cnt[0], 1);

    // Never converges: limit of 5 iterations, then the next start clears timeout.
    reset_mon(0);
    pulse_start(0, 2);
    wait_done(0, 200);
    chk("s3_iter", 0, iter_at_done[0], 5);
    chk("s3_timeout", 0, to_at_done[0], 1);
    chk("s3_checks", 0, chk_cnt[0], 5);
    cyc(2);
    chk("s3_timeout_hold", 0, int'(act_ctrl[0][0]), 1);
    chk("s3_iter_hold", 0, int'(act_it[0]), 5);
    st[0] = 1'b1;
    cyc(1);
    chk("s3_timeout_clr", 0, int'(act_ctrl[0][0]), 0);
    chk("s3_iter_clr", 0, int'(act_it[0]), 0);
    st[0] = 1'b0;
    fi[0] = 1'b1;
    wait_done(0, 60);
    fi[0] = 1'b0;
    cyc(2);

    // Convergence in the same CHECK that reaches the limit.
    reset_mon(0);
    pulse_start(0, 1);
    wait_chk(0, 4, 200);
    fi[0] = 1'b1;
    wait_done(0, 60);
    fi[0] = 1'b0;
    chk("s4_iter", 0, iter_at_done[0], 5);
    chk("s4_timeout", 0, to_at_done[0], 0);
    chk("s4_checks", 0, chk_cnt[0], 5);
    cyc(2);

    // Abort in the first MULT cycle of iteration 2.
    reset_mon(0);
    pulse_start(0, 1);
    wait_chk(0, 1, 60);
    chk("s5_in_mult", 0, int'(act_ctrl[0][4]), 1);
    ab[0] = 1'b1;
    cyc(1);
    ab[0] = 1'b0;
    chk("s5_done", 0, int'(act_ctrl[0][1]), 1);
    chk("s5_iter", 0, int'(act_it[0]), 1);
    chk("s5_timeout", 0, int'(act_ctrl[0][0]), 0);
    cyc(1);
    chk("s5_busy_after", 0, int'(act_ctrl[0][2]), 0);
    chk("s5_done_cycles", 0, done_cnt[0], 1);
    cyc(2);

    // Asynchronous reset in the middle of ADD.
    reset_mon(0);
    pulse_start(0, 1);
    cyc(4);
    chk("s6_in_add", 0, int'(act_ctrl[0][3]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("s6_rst_ctrl", 0, int'(act_ctrl[0]), 0);
    chk("s6_rst_ch", 0, int'(act_ch[0]), 0);
    chk("s6_rst_iter", 0, int'(act_it[0]), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc(2);
    chk("s6_busy_after", 0, int'(act_ctrl[0][2]), 0);
    chk("s6_no_done", 0, done_cnt[0], 0);

    // Random traffic on both configurations, checked every cycle by the model.
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 2; d++) begin
        st[d] = ($urandom_range(0, 3) == 0);
        ab[d] = ($urandom_range(0, 299) == 0);
        fi[d] = ($urandom_range(0, 4) == 0);
      end
      cyc(1);
    end
    st = '0; ab = '0; fi = '1;
    cyc(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
